// File: rtl/watch_time_ctrl.sv
// Watch timekeeping (BCD hh:mm:ss), RUN/SET_HR/SET_MIN mode FSM and 6-digit display scan.
// Registered: time, mode, scan digit and blink phase update one cycle after their enabling input.
module watch_time_ctrl #(
   parameter int HOUR_MAX = 23
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       scan_tick,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic [1:0] mode,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic [2:0] digit_sel,
   output logic [3:0] digit_val,
   output logic       digit_blank
);

   typedef enum logic [1:0] {
      MODE_RUN     = 2'd0,
      MODE_SET_HR  = 2'd1,
      MODE_SET_MIN = 2'd2
   } mode_e;

   localparam logic [7:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

   mode_e      mode_q, mode_d;
   logic [7:0] hour_q, hour_d;
   logic [7:0] min_q, min_d;
   logic [7:0] sec_q, sec_d;
   logic [2:0] sel_q, sel_d;
   logic       blink_q, blink_d;

   // BCD increment that wraps to 00 once the field reaches its top value.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
      logic [7:0] r;
      if (v == top) begin
         r = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   always_comb begin
      mode_d = mode_q;
      hour_d = hour_q;
      min_d  = min_q;
      sec_d  = sec_q;
      case (mode_q)
         MODE_RUN: begin
            if (tick_1hz) begin
               sec_d = bcd_inc(sec_q, 8'h59);
               if (sec_q == 8'h59) begin
                  min_d = bcd_inc(min_q, 8'h59);
                  if (min_q == 8'h59) begin
                     hour_d = bcd_inc(hour_q, HOUR_MAX_BCD);
                  end
               end
            end
            if (mode_btn) begin
               mode_d = MODE_SET_HR;
            end
         end
         MODE_SET_HR: begin
            if (mode_btn) begin
               mode_d = MODE_SET_MIN;
            end else if (inc_btn) begin
               hour_d = bcd_inc(hour_q, HOUR_MAX_BCD);
            end
         end
         MODE_SET_MIN: begin
            // Returning to RUN restarts the minute cleanly; any tick this cycle is dropped.
            if (mode_btn) begin
               mode_d = MODE_RUN;
               sec_d  = 8'h00;
            end else if (inc_btn) begin
               min_d = bcd_inc(min_q, 8'h59);
            end
         end
         default: begin
            mode_d = MODE_RUN;
         end
      endcase
   end

   always_comb begin
      blink_d = blink_q ^ tick_2hz;
      sel_d   = sel_q;
      if (scan_tick) begin
         sel_d = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= MODE_RUN;
         hour_q  <= 8'h00;
         min_q   <= 8'h00;
         sec_q   <= 8'h00;
         sel_q   <= 3'd0;
         blink_q <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         hour_q  <= hour_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         sel_q   <= sel_d;
         blink_q <= blink_d;
      end
   end

   always_comb begin
      digit_val   = 4'd0;
      digit_blank = 1'b0;
      case (sel_q)
         3'd0:    digit_val = hour_q[7:4];
         3'd1:    digit_val = hour_q[3:0];
         3'd2:    digit_val = min_q[7:4];
         3'd3:    digit_val = min_q[3:0];
         3'd4:    digit_val = sec_q[7:4];
         3'd5:    digit_val = sec_q[3:0];
         default: digit_val = 4'd0;
      endcase
      // Only the field being edited flashes.
      if (blink_q) begin
         if (mode_q == MODE_SET_HR && (sel_q == 3'd0 || sel_q == 3'd1)) begin
            digit_blank = 1'b1;
         end
         if (mode_q == MODE_SET_MIN && (sel_q == 3'd2 || sel_q == 3'd3)) begin
            digit_blank = 1'b1;
         end
      end
   end

   assign mode      = mode_q;
   assign hour_bcd  = hour_q;
   assign min_bcd   = min_q;
   assign sec_bcd   = sec_q;
   assign digit_sel = sel_q;

endmodule

// File: tb/tb_watch_time_ctrl.sv
// Bench for watch_time_ctrl: a 23-hour and an 11-hour instance share stimulus; table vectors plus model-driven sequences.
module tb_watch_time_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick_1hz = 1'b0, tick_2hz = 1'b0, scan_tick = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0;

   logic [1:0] mode, mode11;
   logic [7:0] hour_bcd, min_bcd, sec_bcd, hour11, min11, sec11;
   logic [2:0] digit_sel, sel11;
   logic [3:0] digit_val, val11;
   logic       digit_blank, blank11;

   watch_time_ctrl #(.HOUR_MAX(23)) u_dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .scan_tick(scan_tick),
      .mode_btn(mode_btn), .inc_btn(inc_btn), .mode(mode), .hour_bcd(hour_bcd), .min_bcd(min_bcd),
      .sec_bcd(sec_bcd), .digit_sel(digit_sel), .digit_val(digit_val), .digit_blank(digit_blank)
   );

   watch_time_ctrl #(.HOUR_MAX(11)) u_dut11 (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .scan_tick(scan_tick),
      .mode_btn(mode_btn), .inc_btn(inc_btn), .mode(mode11), .hour_bcd(hour11), .min_bcd(min11),
      .sec_bcd(sec11), .digit_sel(sel11), .digit_val(val11), .digit_blank(blank11)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] md;
      logic [7:0] hr;
      logic [7:0] hr11;
      logic [7:0] mn;
      logic [7:0] sc;
      logic [2:0] sel;
      logic [3:0] val;
      logic       blk;
   } exp_t;

   typedef struct packed {
      logic [4:0] in;   // {tick_1hz, tick_2hz, scan_tick, mode_btn, inc_btn}
      exp_t       e;
   } vec_t;

   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] T1   = 5'b10000;
   localparam logic [4:0] T2   = 5'b01000;
   localparam logic [4:0] SC   = 5'b00100;
   localparam logic [4:0] MB   = 5'b00010;
   localparam logic [4:0] IB   = 5'b00001;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   vec_t tbl[19];

   // Reference model kept in plain integers.
   int m_mode, m_h, m_h11, m_m, m_s, m_sel;
   bit m_blink;

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic vec_t mk(input logic [4:0] in, input logic [1:0] md, input logic [7:0] hr,
                               input logic [7:0] mn, input logic [7:0] sc, input logic [2:0] sel,
                               input logic [3:0] val, input logic blk);
      vec_t v;
      v.in = in; v.e.md = md; v.e.hr = hr; v.e.hr11 = hr; v.e.mn = mn; v.e.sc = sc;
      v.e.sel = sel; v.e.val = val; v.e.blk = blk;
      return v;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_h = 0; m_h11 = 0; m_m = 0; m_s = 0; m_sel = 0; m_blink = 0;
   endtask

   task automatic model_advance();
      m_s = m_s + 1;
      if (m_s == 60) begin
         m_s = 0;
         m_m = m_m + 1;
         if (m_m == 60) begin
            m_m = 0;
            m_h = (m_h == 23) ? 0 : m_h + 1;
            m_h11 = (m_h11 == 11) ? 0 : m_h11 + 1;
         end
      end
   endtask

   task automatic model_update(input logic [4:0] in);
      if (in[1]) begin
         if (m_mode == 0) begin
            if (in[4]) model_advance();
            m_mode = 1;
         end else if (m_mode == 1) begin
            m_mode = 2;
         end else begin
            m_s = 0;
            m_mode = 0;
         end
      end else begin
         if (m_mode == 0 && in[4]) model_advance();
         if (m_mode == 1 && in[0]) begin
            m_h = (m_h == 23) ? 0 : m_h + 1;
            m_h11 = (m_h11 == 11) ? 0 : m_h11 + 1;
         end
         if (m_mode == 2 && in[0]) m_m = (m_m + 1) % 60;
      end
      if (in[3]) m_blink = !m_blink;
      if (in[2]) m_sel = (m_sel + 1) % 6;
   endtask

   function automatic exp_t model_exp();
      exp_t e;
      int   d;
      e.md = 2'(m_mode); e.hr = to_bcd(m_h); e.hr11 = to_bcd(m_h11);
      e.mn = to_bcd(m_m); e.sc = to_bcd(m_s); e.sel = 3'(m_sel);
      case (m_sel)
         0: d = m_h / 10;
         1: d = m_h % 10;
         2: d = m_m / 10;
         3: d = m_m % 10;
         4: d = m_s / 10;
         default: d = m_s % 10;
      endcase
      e.val = 4'(d);
      e.blk = m_blink && ((m_mode == 1 && m_sel < 2) || (m_mode == 2 && (m_sel == 2 || m_sel == 3)));
      return e;
   endfunction

   task automatic check(input string name);
      exp_t e, act;
      act = {mode, hour_bcd, hour11, min_bcd, sec_bcd, digit_sel, digit_val, digit_blank};
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL %s: scoreboard empty, got %h", name, act);
      end else begin
         e = sb.pop_front();
         if (act !== e) begin
            miscompares++;
            $display("FAIL %s: got md=%0d hr=%h hr11=%h mn=%h sc=%h sel=%0d val=%0d blk=%b, want md=%0d hr=%h hr11=%h mn=%h sc=%h sel=%0d val=%0d blk=%b",
                     name, act.md, act.hr, act.hr11, act.mn, act.sc, act.sel, act.val, act.blk,
                     e.md, e.hr, e.hr11, e.mn, e.sc, e.sel, e.val, e.blk);
         end
      end
   endtask

   task automatic apply(input logic [4:0] in, input exp_t e, input string name);
      {tick_1hz, tick_2hz, scan_tick, mode_btn, inc_btn} = in;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check(name);
      {tick_1hz, tick_2hz, scan_tick, mode_btn, inc_btn} = NONE;
   endtask

   task automatic step(input logic [4:0] in, input string name);
      model_update(in);
      apply(in, model_exp(), name);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      {tick_1hz, tick_2hz, scan_tick, mode_btn, inc_btn} = 5'b11111;
      model_reset();
      sb.delete();
      sb.push_back(model_exp());
      @(posedge clk);
      #1;
      check("reset_hold");
      {tick_1hz, tick_2hz, scan_tick, mode_btn, inc_btn} = NONE;
      rst = 1'b0;
   endtask

   initial begin
      tbl[0]  = mk(T1,      2'd0, 8'h00, 8'h00, 8'h01, 3'd0, 4'd0, 1'b0);
      tbl[1]  = mk(SC,      2'd0, 8'h00, 8'h00, 8'h01, 3'd1, 4'd0, 1'b0);
      tbl[2]  = mk(SC,      2'd0, 8'h00, 8'h00, 8'h01, 3'd2, 4'd0, 1'b0);
      tbl[3]  = mk(SC,      2'd0, 8'h00, 8'h00, 8'h01, 3'd3, 4'd0, 1'b0);
      tbl[4]  = mk(SC,      2'd0, 8'h00, 8'h00, 8'h01, 3'd4, 4'd0, 1'b0);
      tbl[5]  = mk(SC,      2'd0, 8'h00, 8'h00, 8'h01, 3'd5, 4'd1, 1'b0);
      tbl[6]  = mk(IB,      2'd0, 8'h00, 8'h00, 8'h01, 3'd5, 4'd1, 1'b0);
      tbl[7]  = mk(MB | T1, 2'd1, 8'h00, 8'h00, 8'h02, 3'd5, 4'd2, 1'b0);
      tbl[8]  = mk(IB,      2'd1, 8'h01, 8'h00, 8'h02, 3'd5, 4'd2, 1'b0);
      tbl[9]  = mk(T1,      2'd1, 8'h01, 8'h00, 8'h02, 3'd5, 4'd2, 1'b0);
      tbl[10] = mk(T2,      2'd1, 8'h01, 8'h00, 8'h02, 3'd5, 4'd2, 1'b0);
      tbl[11] = mk(SC,      2'd1, 8'h01, 8'h00, 8'h02, 3'd0, 4'd0, 1'b1);
      tbl[12] = mk(SC,      2'd1, 8'h01, 8'h00, 8'h02, 3'd1, 4'd1, 1'b1);
      tbl[13] = mk(MB | IB, 2'd2, 8'h01, 8'h00, 8'h02, 3'd1, 4'd1, 1'b0);
      tbl[14] = mk(IB,      2'd2, 8'h01, 8'h01, 8'h02, 3'd1, 4'd1, 1'b0);
      tbl[15] = mk(SC,      2'd2, 8'h01, 8'h01, 8'h02, 3'd2, 4'd0, 1'b1);
      tbl[16] = mk(SC,      2'd2, 8'h01, 8'h01, 8'h02, 3'd3, 4'd1, 1'b1);
      tbl[17] = mk(T2,      2'd2, 8'h01, 8'h01, 8'h02, 3'd3, 4'd1, 1'b0);
      tbl[18] = mk(MB,      2'd0, 8'h01, 8'h01, 8'h00, 3'd3, 4'd1, 1'b0);

      #2;
      do_reset();
      for (int i = 0; i < 19; i++) begin
         model_update(tbl[i].in);
         apply(tbl[i].in, tbl[i].e, $sformatf("tbl%0d", i));
      end

      // 61 seconds from reset, no scanning.
      do_reset();
      repeat (61) step(T1, "run_61");

      // Preload 23:59:59 (11:59:59 on the 11-hour instance), then one full rollover.
      do_reset();
      step(MB, "pre_sethr");
      repeat (23) step(IB, "pre_hr");
      step(MB, "pre_setmin");
      repeat (59) step(IB, "pre_min");
      step(MB, "pre_run");
      repeat (59) step(T1, "pre_sec");
      step(T1, "rollover");
      step(T1, "after_roll");

      // Hour set wraps past the top; ticks frozen.
      do_reset();
      step(MB, "hr25_mode");
      for (int i = 0; i < 25; i++) begin
         step(IB, "hr25_inc");
         if (i % 8 == 3) step(T1, "hr25_tick");
      end

      // Exit SET_MIN coincident with a tick.
      do_reset();
      repeat (37) step(T1, "sec37");
      step(MB, "sm_hr");
      step(MB, "sm_min");
      step(T1, "sm_tick_ign");
      step(MB | T1, "sm_exit");
      step(T1, "sm_after");

      // Scan sequence in SET_MIN with blink phase high.
      step(MB, "scan_hr");
      step(MB | T2, "scan_min");
      repeat (7) step(SC, "scan");
      step(SC | T2 | IB, "scan_mix");

      // Asynchronous reset between clock edges in SET_HR.
      step(MB, "ar_run");
      step(MB, "ar_sethr");
      step(IB, "ar_inc");
      step(SC | T2, "ar_scan");
      #3;
      rst = 1'b1;
      #1;
      vectors++;
      if ({mode, hour_bcd, hour11, min_bcd, sec_bcd, digit_sel, digit_val, digit_blank} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: got md=%0d hr=%h hr11=%h mn=%h sc=%h sel=%0d val=%0d blk=%b, want all zero",
                  mode, hour_bcd, hour11, min_bcd, sec_bcd, digit_sel, digit_val, digit_blank);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(IB, "post_ar_ib");
      step(T1, "post_ar_tick");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
